// File: rtl/mode_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mode_select: steps the voice mode on a keypad press with a muted switch
// and a press hold-off window.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mode_select #(
  parameter int NUM_MODES      = 4,
  parameter int MUTE_CYCLES    = 256,
  parameter int HOLDOFF_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         modekey,
  output logic [$clog2(NUM_MODES)-1:0] mode,
  output logic [NUM_MODES-1:0]         mode_onehot,
  output logic                         mute,
  output logic                         mode_changed,
  output logic                         busy
);

  localparam int MW   = $clog2(NUM_MODES);
  localparam int CMAX = (MUTE_CYCLES > HOLDOFF_CYCLES) ? MUTE_CYCLES : HOLDOFF_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] MUTE_LAST    = CW'(MUTE_CYCLES - 1);
  localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [MW-1:0] MODE_LAST    = MW'(NUM_MODES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MUTE_PRE  = 3'd1;
  localparam logic [2:0] S_SWITCH    = 3'd2;
  localparam logic [2:0] S_MUTE_POST = 3'd3;
  localparam logic [2:0] S_HOLDOFF   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [MW-1:0] mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
    end
  end

  // Counter is cleared on every state change so each phase counts from zero.
  always_comb begin
    state_d = state_q;
    count_d = count_q + CW'(1);
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (modekey) state_d = S_MUTE_PRE;
      end
      S_MUTE_PRE: begin
        if (count_q == MUTE_LAST) begin
          state_d = S_SWITCH;
          count_d = '0;
          mode_d  = (mode_q == MODE_LAST) ? '0 : mode_q + MW'(1);
        end
      end
      S_SWITCH: begin
        state_d = S_MUTE_POST;
        count_d = '0;
      end
      S_MUTE_POST: begin
        if (count_q == MUTE_LAST) begin
          state_d = S_HOLDOFF;
          count_d = '0;
        end
      end
      S_HOLDOFF: begin
        if (count_q == HOLDOFF_LAST) begin
          state_d = S_IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    mode_onehot         = '0;
    mode_onehot[mode_q] = 1'b1;
    mode                = mode_q;
    mute                = (state_q == S_MUTE_PRE) || (state_q == S_SWITCH) ||
                          (state_q == S_MUTE_POST);
    mode_changed        = (state_q == S_SWITCH);
    busy                = (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_mode_select.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mode_select: scoreboard bench for mode_select (M=4, H=8).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mode_select;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       modekey = 1'b0;
  logic [1:0] mode;
  logic [3:0] mode_onehot;
  logic       mute;
  logic       mode_changed;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    int         at;
    logic [1:0] mode;
    logic [3:0] oh;
  } ev_t;
  ev_t sb[$];

  mode_select #(.NUM_MODES(4), .MUTE_CYCLES(4), .HOLDOFF_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .modekey(modekey), .mode(mode),
    .mode_onehot(mode_onehot), .mute(mute), .mode_changed(mode_changed),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every mode_changed strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (mode_changed === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_mode_changed", 32'd1, 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("changed_cycle", cyc, e.at);
        check("changed_mode", {30'd0, mode}, {30'd0, e.mode});
        check("changed_onehot", {28'd0, mode_onehot}, {28'd0, e.oh});
        check("changed_mute", {31'd0, mute}, 32'd1);
      end
    end
  end

  function automatic ev_t mk(input int at, input logic [1:0] m);
    ev_t e;
    e.at = at;
    e.mode = m;
    e.oh = 4'b0001 << m;
    return e;
  endfunction

  // Drive a one-cycle press; returns the cycle index of the press (cycle 0).
  task automatic press(output int c0);
    @(negedge clk);
    c0 = cyc;
    modekey = 1'b1;
    @(negedge clk);
    modekey = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle_state(input string name, input logic [1:0] m);
    check({name, "_mode"}, {30'd0, mode}, {30'd0, m});
    check({name, "_onehot"}, {28'd0, mode_onehot}, {28'd0, 4'b0001 << m});
    check({name, "_mute"}, {31'd0, mute}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_changed"}, {31'd0, mode_changed}, 32'd0);
  endtask

  initial begin
    int c0;
    logic [1:0] m;

    // 1. reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_state("reset", 2'd0);

    // 2. single press, cycle-accurate mute/busy profile
    press(c0);
    sb.push_back(mk(c0 + 5, 2'd1));
    for (int k = 1; k <= 20; k++) begin
      check($sformatf("t2_mute_c%0d", k), {31'd0, mute}, {31'd0, (k >= 1 && k <= 9)});
      check($sformatf("t2_busy_c%0d", k), {31'd0, busy}, {31'd0, (k >= 1 && k <= 17)});
      @(negedge clk);
    end

    // 3. four back-to-back presses from reset, including wrap
    do_reset(2);
    m = 2'd0;
    for (int i = 0; i < 4; i++) begin
      press(c0);
      m = m + 2'd1;
      sb.push_back(mk(c0 + 5, m));
      wait_idle();
    end
    check_idle_state("t3_after_wrap", 2'd0);

    // 4. presses during busy are dropped
    press(c0);
    sb.push_back(mk(c0 + 5, 2'd1));
    while (cyc < c0 + 3) @(negedge clk);
    modekey = 1'b1; @(negedge clk); modekey = 1'b0;
    while (cyc < c0 + 7) @(negedge clk);
    modekey = 1'b1; @(negedge clk); modekey = 1'b0;
    while (cyc < c0 + 15) @(negedge clk);
    modekey = 1'b1; @(negedge clk); modekey = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check_idle_state("t4_ignored", 2'd1);

    // 5. reset during MUTE_POST aborts and returns mode to 0
    press(c0);
    sb.push_back(mk(c0 + 5, 2'd2));
    while (cyc < c0 + 6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_state("t5_abort", 2'd0);
    press(c0);
    sb.push_back(mk(c0 + 5, 2'd1));
    wait_idle();
    check_idle_state("t5_after", 2'd1);

    // 6. held key auto-steps; released before the third IDLE sample (cycle 36)
    do_reset(2);
    @(negedge clk);
    c0 = cyc;
    modekey = 1'b1;
    sb.push_back(mk(c0 + 5, 2'd1));
    sb.push_back(mk(c0 + 23, 2'd2));
    while (cyc < c0 + 19) @(negedge clk);
    check("t6_second_start_busy", {31'd0, busy}, 32'd1);
    check("t6_second_start_mute", {31'd0, mute}, 32'd1);
    while (cyc < c0 + 36) @(negedge clk);
    modekey = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check_idle_state("t6_end", 2'd2);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
